// File: rtl/seg_scan_ctrl.sv
// Converter sequencer and multiplexed 7-segment scan driver.
// Optional macro SEG_LEAD_ZERO_BLANK_EN enables leading-zero blanking at shadow load.
module seg_scan_ctrl #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 2,
    parameter int CONV_LAT  = 3
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_hex,
    output logic [7:0] conv_hex,
    input  logic [6:0] conv_digi_0,
    input  logic [6:0] conv_digi_1,
    input  logic [6:0] conv_digi_2,
    output logic       busy,
    output logic       upd_done,
    output logic [6:0] seg,
    output logic [2:0] dig_en
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int WW = (CONV_LAT > 0) ? $clog2(CONV_LAT + 1) : 1;
    localparam logic [6:0] ZERO_CODE = 7'b0111111;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t        state, state_nxt;
    logic [WW-1:0] cnt, cnt_nxt;
    logic          accept;
    logic          load;
    logic [6:0]    shadow_0, shadow_1, shadow_2;
    logic [6:0]    ld_1, ld_2;
    logic [PW-1:0] presc, presc_nxt;
    logic [1:0]    slot, slot_nxt;
    logic [6:0]    seg_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        load      = 1'b0;
        in_ready  = 1'b0;
        busy      = 1'b0;
        unique case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    cnt_nxt   = WW'(CONV_LAT);
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    load      = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ld_1 = conv_digi_1;
        ld_2 = conv_digi_2;
`ifdef SEG_LEAD_ZERO_BLANK_EN
        // A zero hundreds digit is dropped; a zero tens digit only if hundreds was.
        if (conv_digi_2 == ZERO_CODE) begin
            ld_2 = 7'b0000000;
            if (conv_digi_1 == ZERO_CODE) begin
                ld_1 = 7'b0000000;
            end
        end
`else
        if (ZERO_CODE == 7'b0000000) begin
            ld_1 = 7'b0000000;
        end
`endif
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            conv_hex <= 8'd0;
            upd_done <= 1'b0;
            shadow_0 <= 7'b0000000;
            shadow_1 <= 7'b0000000;
            shadow_2 <= 7'b0000000;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            upd_done <= load;
            if (accept) begin
                conv_hex <= in_hex;
            end
            if (load) begin
                shadow_0 <= conv_digi_0;
                shadow_1 <= ld_1;
                shadow_2 <= ld_2;
            end
        end
    end

    always_comb begin
        presc_nxt = presc + 1'b1;
        slot_nxt  = slot;
        if (presc == PW'(SCAN_DIV - 1)) begin
            presc_nxt = '0;
            slot_nxt  = (slot == 2'd2) ? 2'd0 : slot + 2'd1;
        end
        seg_nxt = 7'b0000000;
        if (int'(presc_nxt) >= BLANK_CYC) begin
            unique case (slot_nxt)
                2'd0:    seg_nxt = shadow_0;
                2'd1:    seg_nxt = shadow_1;
                2'd2:    seg_nxt = shadow_2;
                default: seg_nxt = 7'b0000000;
            endcase
        end
    end

    // seg and dig_en are registered from the next-slot view so they move together.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            presc  <= '0;
            slot   <= 2'd0;
            dig_en <= 3'b001;
            seg    <= 7'b0000000;
        end else begin
            presc  <= presc_nxt;
            slot   <= slot_nxt;
            dig_en <= 3'b001 << slot_nxt;
            seg    <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a behavioural 3-cycle hex-to-7seg converter.
module tb_seg_scan_ctrl;

    logic       clock = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_hex;
    logic [7:0] conv_hex;
    logic [6:0] conv_digi_0, conv_digi_1, conv_digi_2;
    logic       busy, upd_done;
    logic [6:0] seg;
    logic [2:0] dig_en;

    int errors = 0;
    int checks = 0;
    int cyc;

    seg_scan_ctrl #(
        .SCAN_DIV (4),
        .BLANK_CYC(1),
        .CONV_LAT (3)
    ) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_hex     (in_hex),
        .conv_hex   (conv_hex),
        .conv_digi_0(conv_digi_0),
        .conv_digi_1(conv_digi_1),
        .conv_digi_2(conv_digi_2),
        .busy       (busy),
        .upd_done   (upd_done),
        .seg        (seg),
        .dig_en     (dig_en)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] seg7(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            default: return 7'h6F;
        endcase
    endfunction

    logic [20:0] p1 = '0, p2 = '0, p3 = '0;
    always @(posedge clock) begin
        p1 <= {seg7(int'(conv_hex) / 100),
               seg7((int'(conv_hex) / 10) % 10),
               seg7(int'(conv_hex) % 10)};
        p2 <= p1;
        p3 <= p2;
    end
    assign {conv_digi_2, conv_digi_1, conv_digi_0} = p3;

    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_slot(input int s);
        bit found = 1'b0;
        for (int k = 0; k < 16 && !found; k++) begin
            tick();
            if (cyc % 4 == 1 && (cyc / 4) % 3 == s) found = 1'b1;
        end
        chk("slot_found", 8'(found), 8'd1);
    endtask

    logic [6:0] exp_sh [3];
    int nb, t, t1, t2, n;
    bit found;

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_hex   = 8'd0;

        // 1: reset
        repeat (5) tick();
        chk("rst_in_ready", 8'(in_ready), 8'd1);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_seg", 8'(seg), 8'd0);
        chk("rst_dig_en", 8'(dig_en), 8'd1);
        chk("rst_conv_hex", conv_hex, 8'd0);
        chk("rst_upd_done", 8'(upd_done), 8'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // 2: accept 0
        in_hex   = 8'd0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("s2_conv_hex", conv_hex, 8'd0);
        nb = 0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (upd_done) found = 1'b1;
            else begin
                if (busy) nb++;
                tick();
            end
        end
        chk("s2_upd_seen", 8'(found), 8'd1);
        chk("s2_busy_cycles", 8'(nb), 8'd4);
        chk("s2_busy_at_done", 8'(busy), 8'd0);
        chk("s2_ready_at_done", 8'(in_ready), 8'd1);
        tick();
        chk("s2_upd_one_cycle", 8'(upd_done), 8'd0);

`ifdef SEG_LEAD_ZERO_BLANK_EN
        exp_sh = '{7'h3F, 7'h00, 7'h00};
`else
        exp_sh = '{7'h3F, 7'h3F, 7'h3F};
`endif

        // 3: scan sequence
        found = 1'b0;
        for (int k = 0; k < 13 && !found; k++) begin
            if (cyc % 12 == 0) found = 1'b1;
            else tick();
        end
        chk("s3_align", 8'(found), 8'd1);
        for (int i = 0; i < 13; i++) begin
            chk($sformatf("s3_dig_en_%0d", i), 8'(dig_en),
                8'(3'b001 << ((i / 4) % 3)));
            chk($sformatf("s3_seg_%0d", i), 8'(seg),
                (i % 4 == 0) ? 8'd0 : 8'(exp_sh[(i / 4) % 3]));
            tick();
        end

        // 4: offer during WAIT
        in_hex   = 8'd7;
        in_valid = 1'b1;
        tick();
        chk("s4_conv_hex7", conv_hex, 8'd7);
        in_hex = 8'd5;
        tick();
        chk("s4_ready_wait", 8'(in_ready), 8'd0);
        chk("s4_hold_conv", conv_hex, 8'd7);
        t = 1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (upd_done) found = 1'b1;
            else begin
                tick();
                t++;
            end
        end
        chk("s4_upd_at_t4", 8'(t), 8'd4);
        chk("s4_conv_still7", conv_hex, 8'd7);
        chk("s4_ready_done", 8'(in_ready), 8'd1);
        tick();
        in_valid = 1'b0;
        chk("s4_conv_hex5", conv_hex, 8'd5);
        chk("s4_busy5", 8'(busy), 8'd1);

        // 5: reset during WAIT at T0+2
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("s5_ready", 8'(in_ready), 8'd1);
        chk("s5_busy", 8'(busy), 8'd0);
        chk("s5_conv_hex", conv_hex, 8'd0);
        chk("s5_dig_en", 8'(dig_en), 8'd1);
        chk("s5_seg", 8'(seg), 8'd0);
        chk("s5_upd", 8'(upd_done), 8'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        nb = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (upd_done || busy || seg != 7'd0) nb++;
        end
        chk("s5_quiet_after", 8'(nb), 8'd0);

        // 6: back-to-back 0 then 5
        in_hex   = 8'd0;
        in_valid = 1'b1;
        tick();
        chk("s6_conv_hex0", conv_hex, 8'd0);
        in_hex = 8'd5;
        n = 0; t1 = 0; t2 = 0;
        for (int k = 1; k < 20 && n < 2; k++) begin
            tick();
            if (n == 1 && k == t1 + 1) begin
                in_valid = 1'b0;
                chk("s6_conv_hex5", conv_hex, 8'd5);
            end
            if (upd_done) begin
                if (n == 0) begin
                    t1 = k;
                    chk("s6_digi0_first", 8'(conv_digi_0), 8'h3F);
                end else begin
                    t2 = k;
                    chk("s6_digi0_second", 8'(conv_digi_0), 8'h6D);
                end
                n++;
            end
        end
        in_valid = 1'b0;
        chk("s6_pulses", 8'(n), 8'd2);
        chk("s6_spacing", 8'(t2 - t1), 8'd5);
        wait_slot(0);
        chk("s6_seg_ones", 8'(seg), 8'h6D);
        wait_slot(1);
`ifdef SEG_LEAD_ZERO_BLANK_EN
        chk("s6_seg_tens", 8'(seg), 8'h00);
`else
        chk("s6_seg_tens", 8'(seg), 8'h3F);
`endif
        wait_slot(2);
`ifdef SEG_LEAD_ZERO_BLANK_EN
        chk("s6_seg_hund", 8'(seg), 8'h00);
`else
        chk("s6_seg_hund", 8'(seg), 8'h3F);
`endif
        chk("s6_dig_en_hund", 8'(dig_en), 8'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
